// File: rtl/mem_resp_pkg.sv
// Shared encodings for the memory-side bus responder.
// MEM_RESP_BURST_EN adds the BURST_DATA state used by 4-byte read bursts.
package mem_resp_pkg;

`ifdef MEM_RESP_BURST_EN
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT       = 2'd1,
    ST_DATA       = 2'd2,
    ST_BURST_DATA = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;
`endif

  localparam logic RD_READ   = 1'b1;
  localparam logic RD_WRITE  = 1'b0;
  localparam int   BURST_LEN = 4;

  // Offsets below BASE wrap to huge values, so a single compare covers both ends.
  function automatic logic in_window(input logic [19:0] offset, input int unsigned depth);
    return {12'b0, offset} < depth;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response strobes between the bus interface unit and the responder.
// BURST is present only when MEM_RESP_BURST_EN is defined.
interface mem_responder_if;
  logic        ALE;
  logic [19:0] Direction;
  logic        RD_WR;
`ifdef MEM_RESP_BURST_EN
  logic        BURST;
`endif
  logic        READY;
  logic        ERR;
  logic        BUSY;

`ifdef MEM_RESP_BURST_EN
  modport master (output ALE, Direction, RD_WR, BURST, input READY, ERR, BUSY);
  modport slave  (input ALE, Direction, RD_WR, BURST, output READY, ERR, BUSY);
`else
  modport master (output ALE, Direction, RD_WR, input READY, ERR, BUSY);
  modport slave  (input ALE, Direction, RD_WR, output READY, ERR, BUSY);
`endif
endinterface

// File: rtl/mem_array.sv
// DEPTH x 8 single-port RAM, synchronous read and write, contents never reset.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: decodes a window, inserts wait states, serves bytes.
// MEM_RESP_BURST_EN enables 4-byte wrapping read bursts via the BURST strobe.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [19:0] BASE        = 20'h00000,
  parameter int          WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  inout  wire  [7:0]      Data
);

  localparam int AW = $clog2(DEPTH);

  state_t        state_reg;
  logic [AW-1:0] addr_reg;
  logic          hit_reg;
  logic          rd_reg;
  logic [3:0]    wait_cnt_reg;
  logic          ready_reg;
  logic          err_reg;
  logic          busy_reg;
  logic          drive_reg;
`ifdef MEM_RESP_BURST_EN
  logic          burst_reg;
  logic [1:0]    beat_cnt_reg;
`endif

  logic [19:0]   offset_in;
  logic          hit_in;
  logic          burst_rd_in;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_rdata;

  assign offset_in = bus.Direction - BASE;
  assign hit_in    = in_window(offset_in, DEPTH);
`ifdef MEM_RESP_BURST_EN
  assign burst_rd_in = bus.BURST && (bus.RD_WR == RD_READ);
`else
  assign burst_rd_in = 1'b0;
`endif

  // With zero wait states the RAM must see the request address on the ALE edge.
  assign ram_addr = (state_reg == ST_IDLE) ? offset_in[AW-1:0] : addr_reg;
  assign ram_we   = (state_reg == ST_DATA) && (rd_reg == RD_WRITE) && hit_reg && reset;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (Data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      hit_reg      <= 1'b0;
      rd_reg       <= RD_WRITE;
      wait_cnt_reg <= '0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      drive_reg    <= 1'b0;
`ifdef MEM_RESP_BURST_EN
      burst_reg    <= 1'b0;
      beat_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          drive_reg <= 1'b0;
          if (bus.ALE) begin
            addr_reg <= offset_in[AW-1:0];
            hit_reg  <= hit_in;
            rd_reg   <= bus.RD_WR;
            busy_reg <= 1'b1;
`ifdef MEM_RESP_BURST_EN
            burst_reg <= burst_rd_in;
`endif
            if (WAIT_STATES == 0) begin
              state_reg <= ST_DATA;
              ready_reg <= 1'b1;
              err_reg   <= !hit_in;
              drive_reg <= (bus.RD_WR == RD_READ);
              // RAM is already fetching beat 0; point the register at beat 1.
              if (burst_rd_in) begin
                addr_reg <= offset_in[AW-1:0] + AW'(1);
              end
            end else begin
              state_reg    <= ST_WAIT;
              wait_cnt_reg <= 4'(WAIT_STATES - 1);
            end
          end
        end

        ST_WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= ST_DATA;
            ready_reg <= 1'b1;
            err_reg   <= !hit_reg;
            drive_reg <= (rd_reg == RD_READ);
`ifdef MEM_RESP_BURST_EN
            if (burst_reg) begin
              addr_reg <= addr_reg + AW'(1);
            end
`endif
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        ST_DATA: begin
`ifdef MEM_RESP_BURST_EN
          if (burst_reg) begin
            state_reg    <= ST_BURST_DATA;
            beat_cnt_reg <= 2'(BURST_LEN - 2);
            addr_reg     <= addr_reg + AW'(1);
          end else begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            drive_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
`else
          state_reg <= ST_IDLE;
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          drive_reg <= 1'b0;
          busy_reg  <= 1'b0;
`endif
        end

`ifdef MEM_RESP_BURST_EN
        ST_BURST_DATA: begin
          // ERR and drive stay as set for beat 0 for the whole burst.
          if (beat_cnt_reg == 2'd0) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            drive_reg <= 1'b0;
            busy_reg  <= 1'b0;
            burst_reg <= 1'b0;
          end else begin
            beat_cnt_reg <= beat_cnt_reg - 2'd1;
            addr_reg     <= addr_reg + AW'(1);
          end
        end
`endif

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.READY = ready_reg;
  assign bus.ERR   = err_reg;
  assign bus.BUSY  = busy_reg;

  // Reset releases the bus combinationally, not at the next edge.
  assign Data = (drive_reg && reset) ? (hit_reg ? ram_rdata : 8'hFF) : 8'hzz;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_STATES=2 and WAIT_STATES=0 instances.
// Burst scenario compiled only with MEM_RESP_BURST_EN.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  wire  [7:0] data_bus;
  wire  [7:0] data_bus0;
  logic       drv = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       drv0 = 1'b0;
  logic [7:0] wdata0 = 8'h00;

  // Idle bus floats high so a released bus reads 8'hFF in any simulator.
  pullup pu_data (data_bus);
  pullup pu_data0 (data_bus0);
  assign data_bus  = drv  ? wdata  : 8'hzz;
  assign data_bus0 = drv0 ? wdata0 : 8'hzz;

  mem_responder #(.DEPTH(1024), .BASE(20'h00000), .WAIT_STATES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .Data  (data_bus)
  );

  mem_responder #(.DEPTH(1024), .BASE(20'h00000), .WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0),
    .Data  (data_bus0)
  );

  int checks = 0;
  int fails  = 0;

  // Presents ALE for one edge; returns at the falling edge of cycle T+1.
  task automatic ale2(input logic [19:0] a, input logic rd);
    @(negedge clk);
    bus.ALE = 1'b1;
    bus.Direction = a;
    bus.RD_WR = rd;
    @(negedge clk);
    bus.ALE = 1'b0;
  endtask

  // Single write on the WAIT_STATES=2 port; returns {READY,ERR} seen at T+3.
  task automatic write2(input logic [19:0] a, input logic [7:0] d, output logic [1:0] re);
    drv = 1'b1;
    wdata = d;
    ale2(a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    re = {bus.READY, bus.ERR};
    @(negedge clk);
    drv = 1'b0;
    $display("txn wr addr=%05h data=%02h ready_err=%b", a, d, re);
  endtask

  // Single read on the WAIT_STATES=2 port; samples Data and {READY,ERR} at T+3.
  task automatic read2(input logic [19:0] a, output logic [7:0] d, output logic [1:0] re);
    ale2(a, 1'b1);
    @(negedge clk);
    @(negedge clk);
    re = {bus.READY, bus.ERR};
    d = data_bus;
    @(negedge clk);
    $display("txn rd addr=%05h data=%02h ready_err=%b", a, d, re);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.READY, bus.ERR, bus.BUSY} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000", {bus.READY, bus.ERR, bus.BUSY});
    end
    checks++;
    if (data_bus !== 8'hFF) begin
      fails++;
      $display("FAIL reset_data_released: got %h expected ff (floating)", data_bus);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [7:0] d;
    logic [1:0] re;
    drv = 1'b1;
    wdata = 8'hA5;
    ale2(20'h00010, 1'b0);
    checks++;
    if ({bus.BUSY, bus.READY} !== 2'b10) begin
      fails++;
      $display("FAIL wr_t1_busy_ready: got %b expected 10", {bus.BUSY, bus.READY});
    end
    @(negedge clk);
    checks++;
    if (bus.READY !== 1'b0) begin
      fails++;
      $display("FAIL wr_t2_ready: got %b expected 0", bus.READY);
    end
    @(negedge clk);
    checks++;
    if ({bus.READY, bus.ERR} !== 2'b10) begin
      fails++;
      $display("FAIL wr_t3_ready_err: got %b expected 10", {bus.READY, bus.ERR});
    end
    @(negedge clk);
    drv = 1'b0;
    checks++;
    if ({bus.BUSY, bus.READY} !== 2'b00) begin
      fails++;
      $display("FAIL wr_t4_idle: got %b expected 00", {bus.BUSY, bus.READY});
    end
    $display("txn wr addr=00010 data=a5");

    ale2(20'h00010, 1'b1);
    @(negedge clk);
    checks++;
    if (data_bus !== 8'hFF) begin
      fails++;
      $display("FAIL rd_t2_data_released: got %h expected ff (floating)", data_bus);
    end
    @(negedge clk);
    re = {bus.READY, bus.ERR};
    d = data_bus;
    checks++;
    if (re !== 2'b10) begin
      fails++;
      $display("FAIL rd_t3_ready_err: got %b expected 10", re);
    end
    checks++;
    if (d !== 8'hA5) begin
      fails++;
      $display("FAIL rd_t3_data: got %h expected a5", d);
    end
    @(negedge clk);
    checks++;
    if ({bus.BUSY, bus.READY, data_bus} !== {2'b00, 8'hFF}) begin
      fails++;
      $display("FAIL rd_t4_idle: got %b/%h expected 00/ff", {bus.BUSY, bus.READY}, data_bus);
    end
    $display("txn rd addr=00010 data=%02h", d);
  endtask

  task automatic test_out_of_window;
    logic [7:0] d;
    logic [1:0] re;
    write2(20'h00000, 8'h5A, re);
    read2(20'h00400, d, re);
    checks++;
    if ({re, d} !== {2'b11, 8'hFF}) begin
      fails++;
      $display("FAIL miss_read: got re=%b data=%h expected re=11 data=ff", re, d);
    end
    write2(20'h00400, 8'h77, re);
    checks++;
    if (re !== 2'b11) begin
      fails++;
      $display("FAIL miss_write_err: got %b expected 11", re);
    end
    read2(20'h00000, d, re);
    checks++;
    if ({re, d} !== {2'b10, 8'h5A}) begin
      fails++;
      $display("FAIL miss_write_discarded: got re=%b data=%h expected re=10 data=5a", re, d);
    end
  endtask

  task automatic test_ignored_ale;
    int ready_count = 0;
    logic [7:0] d3 = 8'h00;
    logic ready_t3 = 1'b0;
    ale2(20'h00010, 1'b1);
    bus.ALE = 1'b1;
    bus.Direction = 20'h00020;
    bus.RD_WR = 1'b1;
    @(negedge clk);
    ready_count += int'(bus.READY);
    @(negedge clk);
    bus.ALE = 1'b0;
    ready_count += int'(bus.READY);
    ready_t3 = bus.READY;
    d3 = data_bus;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ready_count += int'(bus.READY);
    end
    $display("txn rd addr=00010 data=%02h (ALE at T+1,T+2 ignored)", d3);
    checks++;
    if (ready_count !== 1) begin
      fails++;
      $display("FAIL ignored_ale_ready_count: got %0d expected 1", ready_count);
    end
    checks++;
    if ({ready_t3, d3} !== {1'b1, 8'hA5}) begin
      fails++;
      $display("FAIL ignored_ale_t3: got ready=%b data=%h expected ready=1 data=a5", ready_t3, d3);
    end
  endtask

  task automatic test_reset_mid_wait;
    int ready_count = 0;
    ale2(20'h00010, 1'b1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.READY, bus.ERR, bus.BUSY} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_wait_outputs: got %b expected 000", {bus.READY, bus.ERR, bus.BUSY});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ready_count += int'(bus.READY);
    end
    $display("txn rd addr=00010 aborted by reset in WAIT");
    checks++;
    if (ready_count !== 0) begin
      fails++;
      $display("FAIL reset_mid_wait_no_ready: got %0d READY cycles expected 0", ready_count);
    end
  endtask

  task automatic test_async_release;
    ale2(20'h00010, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_bus !== 8'hA5) begin
      fails++;
      $display("FAIL release_pre_data: got %h expected a5", data_bus);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.READY, data_bus} !== {1'b0, 8'hFF}) begin
      fails++;
      $display("FAIL release_async: got ready=%b data=%h expected ready=0 data=ff", bus.READY, data_bus);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    $display("txn rd addr=00010 data bus released by reset");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drv0 = 1'b1;
    wdata0 = 8'h3C;
    bus0.ALE = 1'b1;
    bus0.Direction = 20'h00005;
    bus0.RD_WR = 1'b0;
    @(negedge clk);
    bus0.ALE = 1'b0;
    checks++;
    if ({bus0.READY, bus0.ERR, bus0.BUSY} !== 3'b101) begin
      fails++;
      $display("FAIL ws0_write_t1: got %b expected 101", {bus0.READY, bus0.ERR, bus0.BUSY});
    end
    @(negedge clk);
    drv0 = 1'b0;
    checks++;
    if ({bus0.READY, bus0.BUSY} !== 2'b00) begin
      fails++;
      $display("FAIL ws0_t2_idle: got %b expected 00", {bus0.READY, bus0.BUSY});
    end
    bus0.ALE = 1'b1;
    bus0.RD_WR = 1'b1;
    @(negedge clk);
    bus0.ALE = 1'b0;
    checks++;
    if ({bus0.READY, bus0.ERR, data_bus0} !== {2'b10, 8'h3C}) begin
      fails++;
      $display("FAIL ws0_b2b_read_t3: got re=%b data=%h expected re=10 data=3c", {bus0.READY, bus0.ERR}, data_bus0);
    end
    @(negedge clk);
    checks++;
    if ({bus0.READY, bus0.BUSY, data_bus0} !== {2'b00, 8'hFF}) begin
      fails++;
      $display("FAIL ws0_t4_idle: got %b/%h expected 00/ff", {bus0.READY, bus0.BUSY}, data_bus0);
    end
    $display("txn ws0 wr addr=00005 data=3c, b2b rd");
  endtask

`ifdef MEM_RESP_BURST_EN
  task automatic test_burst;
    logic [1:0] re;
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h11;
    exp_data[1] = 8'h22;
    exp_data[2] = 8'h33;
    exp_data[3] = 8'h44;
    write2(20'h003FE, 8'h11, re);
    write2(20'h003FF, 8'h22, re);
    write2(20'h00000, 8'h33, re);
    write2(20'h00001, 8'h44, re);
    bus.BURST = 1'b1;
    ale2(20'h003FE, 1'b1);
    bus.BURST = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      $display("txn burst beat %0d data=%02h", i, data_bus);
      checks++;
      if ({bus.READY, bus.ERR, data_bus} !== {2'b10, exp_data[i]}) begin
        fails++;
        $display("FAIL burst_beat%0d: got re=%b data=%h expected re=10 data=%h", i, {bus.READY, bus.ERR}, data_bus, exp_data[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.READY, bus.BUSY} !== 2'b00) begin
      fails++;
      $display("FAIL burst_end: got %b expected 00", {bus.READY, bus.BUSY});
    end
  endtask
`endif

  initial begin
    bus.ALE = 1'b0;
    bus.Direction = 20'h0;
    bus.RD_WR = 1'b1;
    bus0.ALE = 1'b0;
    bus0.Direction = 20'h0;
    bus0.RD_WR = 1'b1;
`ifdef MEM_RESP_BURST_EN
    bus.BURST = 1'b0;
    bus0.BURST = 1'b0;
`endif
    test_reset;
    test_write_read;
    test_out_of_window;
    test_ignored_ale;
    test_reset_mid_wait;
    test_async_release;
    test_back_to_back;
`ifdef MEM_RESP_BURST_EN
    test_burst;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side bus responder: the far end of the bus interface unit's external bus. It accepts a 20-bit physical address and a read/write request from the bus interface, services it against an internal byte array after a programmable number of wait states, and drives or samples the 8-bit data bus. It is the memory model that feeds the instruction queue and data accesses in the system-level bench and FPGA builds.

## Interface
- DEPTH, 1024: bytes of storage; power of two.
- BASE, 20'h00000: first physical address decoded; window is [BASE, BASE+DEPTH).
- WAIT_STATES, 2: idle cycles between address latch and data phase; 0–15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ALE  in  1  address latch enable; one-cycle request strobe.
- Direction  in  20  physical address, valid with ALE.
- RD_WR  in  1  1 = read (responder drives Data), 0 = write (responder samples Data); valid with ALE.
- Data  inout  8  external data bus; driven only during a read data phase, else high-Z.
- READY  out  1  one-cycle pulse per transferred byte.
- ERR  out  1  pulses with READY when the address is outside the window.
- BUSY  out  1  high from the cycle after an accepted ALE until the last READY.
- BURST  in  1  (only with MEM_RESP_BURST_EN) request 4-byte read burst; valid with ALE.

## Operation
- States: IDLE, WAIT, DATA (plus BURST_DATA with the macro).
- IDLE: ALE=1 latches Direction, RD_WR, BURST; computes offset = Direction − BASE; hit = offset < DEPTH. Next state WAIT if WAIT_STATES>0, else DATA.
- WAIT: down-counter loaded with WAIT_STATES−1; on reaching 0, go to DATA.
- DATA, read: Data driven with mem[offset[log2(DEPTH)-1:0]] (8'hFF on miss), READY=1, ERR=!hit; next IDLE.
- DATA, write: Data sampled; if hit, mem[offset] written at the end of the cycle; miss discards the write; READY=1, ERR=!hit; next IDLE.
- ALE while BUSY: ignored, no queuing, no error.
- Address arithmetic 20-bit unsigned; Direction < BASE underflows to a large offset, i.e. a miss.
- Storage is not reset; contents survive reset.
- Reset (any time, including mid-burst): state IDLE, READY=0, ERR=0, BUSY=0, Data released to high-Z immediately (asynchronously), pending write discarded.

## Timing
- ALE sampled at edge T. READY high in cycle T+1+WAIT_STATES (registered); BUSY high cycles T+1 through the READY cycle.
- Read data valid on Data exactly in the READY cycle; Data high-Z in every other cycle.
- Write data must be valid on Data in the READY cycle; sampled at the edge ending it.
- Back-to-back: next ALE accepted in the cycle after the last READY (BUSY=0 in that cycle).
- Memory read is synchronous; address registered at ALE, array output ready by DATA for any WAIT_STATES≥0.

## Configuration
- MEM_RESP_BURST_EN defined: BURST port present. Read with BURST=1 gives 4 bytes in 4 consecutive cycles after the wait states, READY high each cycle, offset incrementing and wrapping modulo DEPTH; ERR evaluated on the start address only and held for all 4 beats. BURST=1 with RD_WR=0 is treated as a single write. Latency to first byte unchanged.
- Not defined: no BURST port, single-byte transfers only, BURST_DATA state not compiled.

## Structure
- mem_resp_pkg: state encoding constants, RD/WR encodings (READ=1, WRITE=0), burst length 4.
- Sub-module mem_array: DEPTH×8 synchronous-read, synchronous-write single-port RAM; controller, counters and tri-state driver stay in mem_responder.

## Test plan
- Reset with Data observed -> READY=0, ERR=0, BUSY=0, Data=8'hZZ; assert reset mid-WAIT -> same within the reset cycle, no READY afterwards.
- Write 8'hA5 to 20'h00010, then read 20'h00010 (WAIT_STATES=2) -> READY at T+3 each, read returns 8'hA5, ERR=0.
- Read 20'h00400 with DEPTH=1024, BASE=0 -> READY and ERR together, Data=8'hFF; write there -> ERR=1, array unchanged.
- ALE pulses at T+1 and T+2 during a busy read -> ignored, exactly one READY at T+3.
- WAIT_STATES=0: ALE at T -> READY at T+1; back-to-back ALE at T+2 accepted -> READY at T+3.
- With MEM_RESP_BURST_EN: preload 0x11,0x22,0x33,0x44 at offsets 0x3FE,0x3FF,0x000,0x001; burst read at 0x3FE -> four READY cycles returning 11,22,33,44.
